// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and data access.
// Optional ARB_RR_EN selects round-robin arbitration; default is fixed priority (data over fetch).
//
// state | meaning
// IDLE  | no transaction outstanding, port free
// BUSY  | transaction outstanding, cnt counts memory latency down to 0
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_D  = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be 1..15");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       owner, owner_nxt;
  logic       done, port_free;
  logic       gnt_if, gnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      owner <= OWN_IF;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
    end
  end

`ifdef ARB_RR_EN
  logic rr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= OWN_D;
    end else if (gnt_if || gnt_d) begin
      rr_last <= gnt_d;
    end
  end
`endif

  // rst gates the free flag so no combinational grant leaks out while reset is held.
  always_comb begin
    done      = (state == BUSY) && (cnt == 4'd0);
    port_free = !rst && ((state == IDLE) || done);
`ifdef ARB_RR_EN
    if (if_req && d_req) begin
      gnt_d  = port_free && (rr_last == OWN_IF);
      gnt_if = port_free && (rr_last == OWN_D);
    end else begin
      gnt_d  = port_free && d_req;
      gnt_if = port_free && if_req;
    end
`else
    gnt_d  = port_free && d_req;
    gnt_if = port_free && if_req && !d_req;
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    if (gnt_if || gnt_d) begin
      state_nxt = BUSY;
      cnt_nxt   = LAT_M1;
      owner_nxt = gnt_d ? OWN_D : OWN_IF;
    end else if (done) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (state == BUSY) begin
      cnt_nxt = cnt - 4'd1;
    end
  end

  always_comb begin
    if_gnt    = gnt_if;
    d_gnt     = gnt_d;
    m_en      = gnt_if || gnt_d;
    m_we      = gnt_d && d_we;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    if (gnt_d) begin
      m_addr = d_addr;
      if (d_we) begin
        m_wdata = d_wdata;
        m_wstrb = d_wstrb;
      end
    end else if (gnt_if) begin
      m_addr = if_addr;
    end
    if_rvalid = done && (owner == OWN_IF);
    d_rvalid  = done && (owner == OWN_D);
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid ? m_rdata : '0;
    busy      = (state == BUSY);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset/arbitration sequences,
// a MEM_LAT=1 instance for back-to-back throughput, and randomized traffic against a reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  logic        b_if_req;
  logic [31:0] b_if_addr, b_m_rdata;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic [3:0]  b_m_wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_wstrb(4'h0),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .m_rdata(b_m_rdata), .busy(b_busy)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] m_rdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_m_en;
    logic        e_m_we;
    logic [31:0] e_m_addr;
    logic [31:0] e_m_wdata;
    logic [3:0]  e_m_wstrb;
    logic        e_busy;
    logic        e_if_rv;
    logic        e_d_rv;
    logic        chk_ird;
    logic        chk_drd;
    logic [31:0] e_if_rd;
    logic [31:0] e_d_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    m_rdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_m_rdata = 32'h0;
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vt[$];

  bit          ip, dp, dwe, ov, own_d, own_we, last_d, cmpl, free, gd, gi;
  logic [31:0] ia, da, dwd, mrd, mem[16];
  logic [3:0]  dws;
  int          done_t, own_idx, ngr;
  bit          win_d[8];

  initial begin
    rst = 1'b1;
    idle_inputs();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; m_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("por_ctl", {21'b0, if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we, busy, m_wstrb}, 32'h0);
    chk("por_data", if_rdata | d_rdata | m_addr | m_wdata, 32'h0);
    idle_inputs();
    rst = 1'b0;

    // directed vectors: fetch read, conflict, write ack
    vt.push_back('{1'b1,32'h10,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0,        1'b1,1'b0,1'b1,1'b0,32'h10,32'h0,4'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'hAAAA5555,  1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b1,1'b0,1'b1,1'b1,32'hAAAA5555,32'h0});
    vt.push_back('{1'b1,32'h20,1'b1,1'b0,32'h80,32'h0,4'h0,32'h0,       1'b0,1'b1,1'b1,1'b0,32'h80,32'h0,4'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b1,32'h20,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b1,32'h20,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0BADF00D, 1'b1,1'b0,1'b1,1'b0,32'h20,32'h0,4'h0,1'b1, 1'b0,1'b1,1'b1,1'b1,32'h0,32'h0BADF00D});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h11112222,  1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b1,1'b0,1'b1,1'b1,32'h11112222,32'h0});
    vt.push_back('{1'b0,32'h0,1'b1,1'b1,32'h40,32'h12345678,4'b0011,32'h0, 1'b0,1'b1,1'b1,1'b1,32'h40,32'h12345678,4'b0011,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'hFFFFFFFF,  1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1, 1'b0,1'b1,1'b1,1'b0,32'h0,32'h0});
    vt.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_addr = vt[i].d_addr;
      d_wdata = vt[i].d_wdata; d_wstrb = vt[i].d_wstrb; m_rdata = vt[i].m_rdata;
      #1;
      chk($sformatf("vec%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, vt[i].e_if_gnt});
      chk($sformatf("vec%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, vt[i].e_d_gnt});
      chk($sformatf("vec%0d_m_en", i), {31'b0, m_en}, {31'b0, vt[i].e_m_en});
      chk($sformatf("vec%0d_m_we", i), {31'b0, m_we}, {31'b0, vt[i].e_m_we});
      chk($sformatf("vec%0d_m_addr", i), m_addr, vt[i].e_m_addr);
      chk($sformatf("vec%0d_m_wdata", i), m_wdata, vt[i].e_m_wdata);
      chk($sformatf("vec%0d_m_wstrb", i), {28'b0, m_wstrb}, {28'b0, vt[i].e_m_wstrb});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vt[i].e_busy});
      chk($sformatf("vec%0d_if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vt[i].e_if_rv});
      chk($sformatf("vec%0d_d_rvalid", i), {31'b0, d_rvalid}, {31'b0, vt[i].e_d_rv});
      if (vt[i].chk_ird) chk($sformatf("vec%0d_if_rdata", i), if_rdata, vt[i].e_if_rd);
      if (vt[i].chk_drd) chk($sformatf("vec%0d_d_rdata", i), d_rdata, vt[i].e_d_rd);
    end

    // reset held for 3 cycles in the middle of a transaction
    @(negedge clk);
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h30;
    #1 chk("mid_rst_pre_gnt", {31'b0, if_gnt}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'h5A5A5A5A;
    m_rdata = 32'hCAFEBABE; b_if_req = 1'b1; b_m_rdata = 32'hCAFEBABE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_ctl", {21'b0, if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we, busy, m_wstrb}, 32'h0);
      chk("rst_data", if_rdata | d_rdata | m_addr | m_wdata, 32'h0);
      chk("rst_ctl_lat1", {25'b0, b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we, b_busy}, 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
    m_rdata = 32'hCAFEBABE;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
      chk("post_rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
    end

    // both requesters held continuously for 8 grants
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    ngr = 0;
    for (int k = 0; k < 40 && ngr < 8; k++) begin
      #1;
      if (if_gnt || d_gnt) begin
        win_d[ngr] = d_gnt;
        ngr++;
      end
      @(negedge clk);
    end
    chk("arb_grant_count", ngr, 8);
    for (int k = 0; k < ngr; k++) begin
`ifdef ARB_RR_EN
      chk($sformatf("rr_winner%0d_is_d", k), {31'b0, win_d[k]}, {31'b0, (k % 2) == 1});
`else
      chk($sformatf("fixed_winner%0d_is_d", k), {31'b0, win_d[k]}, 32'h1);
`endif
    end
    idle_inputs();
    repeat (3) @(negedge clk);

    // MEM_LAT=1 back-to-back fetches
    for (int k = 0; k < 6; k++) begin
      b_if_req = (k < 4);
      b_if_addr = 32'(k * 4);
      b_m_rdata = 32'h100 + 32'(k);
      #1;
      chk($sformatf("lat1_gnt%0d", k), {31'b0, b_if_gnt}, {31'b0, k < 4});
      chk($sformatf("lat1_rvalid%0d", k), {31'b0, b_if_rvalid}, {31'b0, k >= 1 && k <= 4});
      chk($sformatf("lat1_busy%0d", k), {31'b0, b_busy}, {31'b0, k >= 1 && k <= 4});
      if (k >= 1 && k <= 4) chk($sformatf("lat1_rdata%0d", k), b_if_rdata, 32'h100 + 32'(k));
      @(negedge clk);
    end
    idle_inputs();

    // randomized traffic against a transaction-level model
    reset_pulse(2);
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    ip = 0; dp = 0; ov = 0; own_d = 0; own_we = 0; own_idx = 0; done_t = 0; last_d = 1;
    ia = 0; da = 0; dwd = 0; dwe = 0; dws = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = 32'($urandom_range(0, 15)) * 4;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; da = 32'($urandom_range(0, 15)) * 4;
        dwe = $urandom_range(0, 1) == 1; dwd = $urandom; dws = 4'($urandom_range(0, 15));
      end
      cmpl = ov && (done_t == c);
      free = !ov || cmpl;
`ifdef ARB_RR_EN
      gd = free && dp && (!ip || !last_d);
`else
      gd = free && dp;
`endif
      gi = free && ip && !gd;
      mrd = (cmpl && !own_we) ? mem[own_idx] : $urandom;
      if_req = ip; if_addr = ia;
      d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dws;
      m_rdata = mrd;
      #1;
      chk("rnd_if_gnt", {31'b0, if_gnt}, {31'b0, gi});
      chk("rnd_d_gnt", {31'b0, d_gnt}, {31'b0, gd});
      chk("rnd_m_en", {31'b0, m_en}, {31'b0, gi || gd});
      chk("rnd_m_we", {31'b0, m_we}, {31'b0, gd && dwe});
      chk("rnd_m_addr", m_addr, gd ? da : (gi ? ia : 32'h0));
      chk("rnd_m_wdata", m_wdata, (gd && dwe) ? dwd : 32'h0);
      chk("rnd_m_wstrb", {28'b0, m_wstrb}, {28'b0, (gd && dwe) ? dws : 4'h0});
      chk("rnd_busy", {31'b0, busy}, {31'b0, ov});
      chk("rnd_if_rvalid", {31'b0, if_rvalid}, {31'b0, cmpl && !own_d});
      chk("rnd_d_rvalid", {31'b0, d_rvalid}, {31'b0, cmpl && own_d});
      if (cmpl) begin
        chk("rnd_if_rdata", if_rdata, own_d ? 32'h0 : mrd);
        if (!own_d) chk("rnd_d_rdata_other", d_rdata, 32'h0);
        else if (!own_we) chk("rnd_d_rdata", d_rdata, mrd);
      end
      @(posedge clk);
      if (gd || gi) begin
        ov = 1; done_t = c + LAT; own_d = gd; own_we = gd && dwe;
        own_idx = gd ? int'(da[5:2]) : int'(ia[5:2]);
        if (gd && dwe)
          for (int b = 0; b < 4; b++)
            if (dws[b]) mem[own_idx][8*b +: 8] = dwd[8*b +: 8];
        last_d = gd;
        if (gd) dp = 0;
        if (gi) ip = 0;
      end else if (cmpl) begin
        ov = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
